// File: rtl/imem_boot_loader_pkg.sv
// Shared boot-loader definitions: memory geometry, derived widths and FSM states.
package imem_boot_loader_pkg;

    localparam int IMEM_DEPTH     = 256;
    localparam int DMEM_BYTES     = 32;
    localparam int WORD_W         = 32;
    localparam int IMEM_AW        = $clog2(IMEM_DEPTH);
    localparam int DMEM_AW        = $clog2(DMEM_BYTES);
    localparam int NUM_W          = IMEM_AW + 1;
    localparam int BYTES_PER_WORD = WORD_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        CLR_I,
        CLR_D,
        LOAD,
        RUN
    } boot_state_t;

    // Requested word count limited to what IMEM can hold.
    function automatic logic [NUM_W-1:0] clamp_words(input logic [NUM_W-1:0] req);
        return (req > NUM_W'(IMEM_DEPTH)) ? NUM_W'(IMEM_DEPTH) : req;
    endfunction

endpackage

// File: rtl/imem_boot_loader_word_packer.sv
// Collects bytes MSB-first and flags the cycle in which a word completes.
// The completed word is presented combinationally so the parent can register
// the IMEM write in the very next cycle.
module imem_boot_loader_word_packer
    import imem_boot_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              byte_en_i,
    input  logic [7:0]        byte_i,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o
);

    localparam int SH_W  = WORD_W - 8;
    localparam int CNT_W = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

    logic [SH_W-1:0]  shift_q;
    logic [CNT_W-1:0] byte_cnt_q;

    assign word_valid_o = byte_en_i && (byte_cnt_q == LAST_BYTE);
    assign word_o       = {shift_q, byte_i};

    // Shift accepted bytes in and track position within the current word.
    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst_i || clear_i) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
        end else if (byte_en_i) begin
            shift_q    <= {shift_q[SH_W-9:0], byte_i};
            byte_cnt_q <= (byte_cnt_q == LAST_BYTE) ? '0 : byte_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot stage ahead of the CPU: clears IMEM and DMEM, streams a program into
// IMEM over a byte link, then releases the CPU. Every output is a flop; the
// combinational process computes the value each output takes after the edge.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [NUM_W-1:0]   num_words_i,
    input  logic               rx_valid_i,
    input  logic [7:0]         rx_data_i,
    output logic               rx_ready_o,
    output logic               imem_we_o,
    output logic [IMEM_AW-1:0] imem_addr_o,
    output logic [WORD_W-1:0]  imem_data_o,
    output logic               dmem_we_o,
    output logic [DMEM_AW-1:0] dmem_addr_o,
    output logic [7:0]         dmem_data_o,
    output logic               cpu_rst_o,
    output logic               cpu_start_o,
    output logic               busy_o,
    output logic               err_o
);

    boot_state_t        state, state_d;
    logic [NUM_W-1:0]   cnt, cnt_d, cnt_inc;
    logic [NUM_W-1:0]   n_words, n_d;
    logic               err_d;
    logic               rx_ready_d;
    logic               imem_we_d;
    logic [IMEM_AW-1:0] imem_addr_d;
    logic [WORD_W-1:0]  imem_data_d;
    logic               dmem_we_d;
    logic [DMEM_AW-1:0] dmem_addr_d;
    logic               cpu_run_d;
    logic               busy_d;
    logic               begin_boot;
    logic               pack_clear;
    logic               word_done;
    logic [WORD_W-1:0]  word;

    // DMEM is only ever cleared, so its write data is tied low.
    assign dmem_data_o = '0;
    assign cnt_inc     = cnt + 1'b1;

    imem_boot_loader_word_packer u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (pack_clear),
        .byte_en_i    (rx_valid_i && rx_ready_o),
        .byte_i       (rx_data_i),
        .word_valid_o (word_done),
        .word_o       (word)
    );

    // Next state, counters and next values of every registered output.
    always_comb begin
        // NOTE: defaults first so no branch leaves a signal unassigned and infers a latch.
        state_d     = state;
        cnt_d       = cnt;
        n_d         = n_words;
        err_d       = err_o;
        rx_ready_d  = 1'b0;
        imem_we_d   = 1'b0;
        imem_addr_d = '0;
        imem_data_d = '0;
        dmem_we_d   = 1'b0;
        dmem_addr_d = '0;
        cpu_run_d   = 1'b0;
        begin_boot  = 1'b0;
        pack_clear  = 1'b0;

        unique case (state)
            IDLE: begin
                begin_boot = load_i;
            end
            CLR_I: begin
                if (cnt == NUM_W'(IMEM_DEPTH - 1)) begin
                    state_d     = CLR_D;
                    cnt_d       = '0;
                    dmem_we_d   = 1'b1;
                    dmem_addr_d = '0;
                end else begin
                    cnt_d       = cnt_inc;
                    imem_we_d   = 1'b1;
                    imem_addr_d = cnt_inc[IMEM_AW-1:0];
                end
            end
            CLR_D: begin
                if (cnt == NUM_W'(DMEM_BYTES - 1)) begin
                    cnt_d = '0;
                    if (n_words == '0) begin
                        state_d   = RUN;
                        cpu_run_d = 1'b1;
                    end else begin
                        state_d    = LOAD;
                        rx_ready_d = 1'b1;
                        pack_clear = 1'b1;
                    end
                end else begin
                    cnt_d       = cnt_inc;
                    dmem_we_d   = 1'b1;
                    dmem_addr_d = cnt_inc[DMEM_AW-1:0];
                end
            end
            LOAD: begin
                // Ready low inside LOAD marks the cycle of the final IMEM write.
                if (!rx_ready_o) begin
                    state_d   = RUN;
                    cpu_run_d = 1'b1;
                end else begin
                    rx_ready_d = 1'b1;
                    if (word_done) begin
                        imem_we_d   = 1'b1;
                        imem_addr_d = cnt[IMEM_AW-1:0];
                        imem_data_d = word;
                        cnt_d       = cnt_inc;
                        if (cnt_inc == n_words) begin
                            rx_ready_d = 1'b0;
                        end
                    end
                end
            end
            RUN: begin
                cpu_run_d  = 1'b1;
                begin_boot = load_i;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (begin_boot) begin
            state_d     = CLR_I;
            cnt_d       = '0;
            n_d         = clamp_words(num_words_i);
            err_d       = (num_words_i > NUM_W'(IMEM_DEPTH));
            imem_we_d   = 1'b1;
            imem_addr_d = '0;
            cpu_run_d   = 1'b0;
        end

        busy_d = (state_d != IDLE) && (state_d != RUN);
    end

    // State, counters and output registers; reset aborts any sequence at once.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            n_words     <= '0;
            err_o       <= 1'b0;
            rx_ready_o  <= 1'b0;
            imem_we_o   <= 1'b0;
            imem_addr_o <= '0;
            imem_data_o <= '0;
            dmem_we_o   <= 1'b0;
            dmem_addr_o <= '0;
            cpu_rst_o   <= 1'b0;
            cpu_start_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            n_words     <= n_d;
            err_o       <= err_d;
            rx_ready_o  <= rx_ready_d;
            imem_we_o   <= imem_we_d;
            imem_addr_o <= imem_addr_d;
            imem_data_o <= imem_data_d;
            dmem_we_o   <= dmem_we_d;
            dmem_addr_o <= dmem_addr_d;
            cpu_rst_o   <= cpu_run_d;
            cpu_start_o <= cpu_run_d;
            busy_o      <= busy_d;
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected memory writes are queued as
// stimulus is issued and popped as the DUT strobes IMEM/DMEM.
module tb_imem_boot_loader;
    import imem_boot_loader_pkg::*;

    typedef struct packed {
        logic        imem;
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               load_i;
    logic [NUM_W-1:0]   num_words_i;
    logic               rx_valid_i;
    logic [7:0]         rx_data_i;
    logic               rx_ready_o;
    logic               imem_we_o;
    logic [IMEM_AW-1:0] imem_addr_o;
    logic [WORD_W-1:0]  imem_data_o;
    logic               dmem_we_o;
    logic [DMEM_AW-1:0] dmem_addr_o;
    logic [7:0]         dmem_data_o;
    logic               cpu_rst_o;
    logic               cpu_start_o;
    logic               busy_o;
    logic               err_o;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  last_write_cyc = 0;
    int  xfers = 0;
    bit  prev_cpu_rst = 1'b0;
    wr_t exp_q[$];

    imem_boot_loader dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (load_i),
        .num_words_i (num_words_i),
        .rx_valid_i  (rx_valid_i),
        .rx_data_i   (rx_data_i),
        .rx_ready_o  (rx_ready_o),
        .imem_we_o   (imem_we_o),
        .imem_addr_o (imem_addr_o),
        .imem_data_o (imem_data_o),
        .dmem_we_o   (dmem_we_o),
        .dmem_addr_o (dmem_addr_o),
        .dmem_data_o (dmem_data_o),
        .cpu_rst_o   (cpu_rst_o),
        .cpu_start_o (cpu_start_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({rx_ready_o, imem_we_o, imem_addr_o, imem_data_o, dmem_we_o,
                    dmem_addr_o, dmem_data_o, cpu_rst_o, cpu_start_o, busy_o, err_o});
    endfunction

    // Write monitor: compares each strobe against the scoreboard and checks
    // that the CPU is released exactly one cycle after the last memory write.
    always @(negedge clk_i) begin
        wr_t got;
        wr_t exp;
        cyc++;
        if (imem_we_o || dmem_we_o) begin
            check("single_strobe", 64'(imem_we_o && dmem_we_o), 64'd0);
            got.imem = imem_we_o;
            got.addr = imem_we_o ? 9'(imem_addr_o) : 9'(dmem_addr_o);
            got.data = imem_we_o ? imem_data_o : 32'(dmem_data_o);
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            else exp = '{imem: 1'b1, addr: 9'h1FF, data: 32'hDEADBEEF};
            check("mem_write", 64'(got), 64'(exp));
            last_write_cyc = cyc;
        end
        if (rx_valid_i && rx_ready_o) xfers++;
        if (cpu_rst_o && !prev_cpu_rst) begin
            check("run_after_last_write", 64'(cyc - last_write_cyc), 64'd1);
            check("cpu_start_with_rst", 64'(cpu_start_o), 64'd1);
            check("sb_empty_at_run", 64'(exp_q.size()), 64'd0);
        end
        prev_cpu_rst = cpu_rst_o;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_load(input int n, input bit push);
        if (push) begin
            for (int i = 0; i < IMEM_DEPTH; i++) exp_q.push_back('{imem: 1'b1, addr: 9'(i), data: 32'h0});
            for (int i = 0; i < DMEM_BYTES; i++) exp_q.push_back('{imem: 1'b0, addr: 9'(i), data: 32'h0});
        end
        num_words_i = NUM_W'(n);
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, input int bound, output bit acc);
        if (gaps) repeat ($urandom_range(0, 3)) tick();
        acc = 1'b0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        for (int i = 0; i < bound && !acc; i++) begin
            @(negedge clk_i);
            if (rx_ready_o) acc = 1'b1;
            tick();
        end
        rx_valid_i = 1'b0;
    endtask

    task automatic send_word(input int idx, input logic [31:0] w, input bit gaps, input bit last);
        bit acc;
        exp_q.push_back('{imem: 1'b1, addr: 9'(idx), data: w});
        for (int k = 0; k < 4; k++) begin
            send_byte(w[31-8*k -: 8], gaps, 1000, acc);
            check("byte_accepted", 64'(acc), 64'd1);
        end
        if (last) check("ready_low_after_last", 64'(rx_ready_o), 64'd0);
    endtask

    task automatic wait_run(input string tag);
        bit reached = 1'b0;
        for (int i = 0; i < 2000 && !reached; i++) begin
            @(negedge clk_i);
            if (cpu_rst_o) reached = 1'b1;
            tick();
        end
        check(tag, 64'(reached), 64'd1);
        check("state_run", 64'(dut.state), 64'(RUN));
    endtask

    initial begin
        bit acc;
        int x0;
        rst_i = 1'b1;
        load_i = 1'b0;
        num_words_i = '0;
        rx_valid_i = 1'b0;
        rx_data_i = '0;

        // 1: reset for 3 cycles, then idle with ignored rx_valid_i
        repeat (3) tick();
        check("reset_outs", all_outs(), 64'd0);
        check("reset_state", 64'(dut.state), 64'(IDLE));
        rst_i = 1'b0;
        rx_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_outs", all_outs(), 64'd0);
            check("idle_state", 64'(dut.state), 64'(IDLE));
        end
        rx_valid_i = 1'b0;
        check("idle_no_xfer", 64'(xfers), 64'd0);

        // 2: single word after full clear
        pulse_load(1, 1'b1);
        check("clr_busy", 64'(busy_o), 64'd1);
        send_word(0, 32'h20080005, 1'b0, 1'b1);
        wait_run("run_n1");

        // 3: three words with random valid bubbles
        pulse_load(3, 1'b1);
        send_word(0, 32'hA1B2C3D4, 1'b1, 1'b0);
        send_word(1, 32'h00FF1234, 1'b1, 1'b0);
        send_word(2, 32'hCAFEF00D, 1'b1, 1'b1);
        wait_run("run_n3");

        // 4a: oversized request clamps to IMEM_DEPTH and flags err_o
        pulse_load(300, 1'b1);
        check("err_set", 64'(err_o), 64'd1);
        x0 = xfers;
        for (int i = 0; i < IMEM_DEPTH; i++) send_word(i, $urandom(), 1'b0, i == IMEM_DEPTH - 1);
        send_byte(8'hAA, 1'b0, 20, acc);
        check("excess_not_consumed", 64'(acc), 64'd0);
        check("xfer_count_256", 64'(xfers - x0), 64'd1024);
        wait_run("run_n300");
        check("err_sticky", 64'(err_o), 64'd1);

        // 4b: zero words goes straight from CLR_D to RUN
        x0 = xfers;
        rx_data_i = 8'h55;
        rx_valid_i = 1'b1;
        pulse_load(0, 1'b1);
        rx_valid_i = 1'b1;
        check("err_cleared", 64'(err_o), 64'd0);
        wait_run("run_n0");
        rx_valid_i = 1'b0;
        check("n0_no_xfer", 64'(xfers - x0), 64'd0);

        // 5: reset after 6 bytes of a 2-word load, then clean restart
        x0 = xfers;
        pulse_load(2, 1'b1);
        send_word(0, 32'h11223344, 1'b0, 1'b0);
        send_byte(8'h55, 1'b0, 1000, acc);
        send_byte(8'h66, 1'b0, 1000, acc);
        check("six_bytes", 64'(xfers - x0), 64'd6);
        rst_i = 1'b1;
        tick();
        check("abort_outs", all_outs(), 64'd0);
        check("abort_state", 64'(dut.state), 64'(IDLE));
        check("abort_sb_empty", 64'(exp_q.size()), 64'd0);
        rst_i = 1'b0;
        tick();
        pulse_load(1, 1'b1);
        send_word(0, 32'h8badf00d, 1'b1, 1'b1);
        wait_run("run_after_abort");

        // 6: reload from RUN; load_i during CLR_I is ignored
        pulse_load(2, 1'b1);
        check("reload_cpu_rst", 64'(cpu_rst_o), 64'd0);
        check("reload_cpu_start", 64'(cpu_start_o), 64'd0);
        check("reload_first_clr", 64'({imem_we_o, imem_addr_o}), 64'({1'b1, 8'd0}));
        repeat (50) tick();
        pulse_load(5, 1'b0);
        check("clr_continues", 64'({dut.state, imem_addr_o}), 64'({CLR_I, 8'd51}));
        send_word(0, 32'h01234567, 1'b1, 1'b0);
        send_word(1, 32'h89ABCDEF, 1'b1, 1'b1);
        wait_run("run_after_reload");

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
